// File: rtl/stack_frame_reverser_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_frame_reverser_pkg
//  Description : Shared types and helpers for the stack frame reverser:
//                the two-state controller enum and the frame counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_frame_reverser_pkg;

  // FILL accepts and pushes a frame; DRAIN pops it back out in reverse.
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Counter must hold every value from 0 up to and including depth.
  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : stack_frame_reverser_pkg
`default_nettype wire

// File: rtl/stack_frame_reverser.sv
`default_nettype none
// ============================================================================
//  Module      : stack_frame_reverser
//  Description : Requester-side controller for an external DW_stack. Pushes
//                each word of an incoming frame onto the stack, then drains
//                the whole frame on the output in reverse (LIFO) order.
//                Words arriving while the stack is full are dropped and the
//                frame is flagged as truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_frame_reverser
  import stack_frame_reverser_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8
) (
  input  logic             clk,
  input  logic             rst,
  // framed input stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  input  logic             in_last,
  // reversed output stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  // stack request side
  output logic             push_req_n,
  output logic             pop_req_n,
  output logic [width-1:0] stk_data_in,
  input  logic [width-1:0] stk_data_out,
  input  logic             stk_empty,
  input  logic             stk_full,
  input  logic             stk_error,
  // status
  output logic             frame_err,
  output logic             stk_fault
);

  localparam int            CW        = CNT_W(depth);
  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            trunc_q, trunc_d;
  logic            stk_fault_q;

  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_last_beat;

  // Handshake qualifiers; a push only happens when the stack has room.
  assign w_accept    = (state_q == FILL)  && in_valid;
  assign w_push      = w_accept && !stk_full;
  assign w_pop       = (state_q == DRAIN) && out_ready;
  assign w_last_beat = w_accept && in_last;

  // Data paths are pure wiring to and from the stack.
  assign stk_data_in = in_data;
  assign out_data    = stk_data_out;
  assign stk_fault   = stk_fault_q;

  // Controller state, frame counter and truncation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Sticky record that the stack ever reported an error; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk_fault_q <= 1'b0;
    end else if (stk_error) begin
      stk_fault_q <= 1'b1;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    trunc_d    = trunc_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    push_req_n = 1'b1;
    pop_req_n  = 1'b1;
    frame_err  = 1'b0;

    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (w_push) begin
          push_req_n = 1'b0;
          cnt_d      = cnt_q + c_cnt_one;
        end
        if (w_last_beat) begin
          // The frame is truncated if any earlier word or this one was dropped.
          frame_err = trunc_q || stk_full;
          trunc_d   = 1'b0;
          // Never enter DRAIN with nothing to pop, or the output would stall.
          if (w_push || (cnt_q != '0)) begin
            state_d = DRAIN;
          end
        end else if (w_accept && stk_full) begin
          trunc_d = 1'b1;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == c_cnt_one);
        if (w_pop) begin
          pop_req_n = 1'b0;
          cnt_d     = cnt_q - c_cnt_one;
          if (cnt_q == c_cnt_one) begin
            state_d = FILL;
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

`ifndef SYNTHESIS
  // Protocol checks on the stack request side.
  a_no_push_and_pop : assert property (@(posedge clk) disable iff (rst)
    !(!push_req_n && !pop_req_n));

  a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
    !(!push_req_n && stk_full));

  a_no_pop_at_zero : assert property (@(posedge clk) disable iff (rst)
    !(!pop_req_n && (cnt_q == '0)));

  a_drain_not_empty : assert property (@(posedge clk) disable iff (rst)
    ((state_q == DRAIN) && (cnt_q != '0)) |-> !stk_empty);
`endif

endmodule : stack_frame_reverser
`default_nettype wire

// File: tb/tb_stack_frame_reverser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_frame_reverser
//  Description : Scoreboard bench for stack_frame_reverser with a behavioural
//                LIFO standing in for the parent-level DW_stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_frame_reverser;

  localparam int W = 8;
  localparam int D = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last;
  logic [W-1:0] in_data;
  logic         out_valid, out_ready, out_last;
  logic [W-1:0] out_data;
  logic         push_req_n, pop_req_n;
  logic [W-1:0] stk_data_in, stk_data_out;
  logic         stk_empty, stk_full, stk_error;
  logic         frame_err, stk_fault;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   npush  = 0;
  int   npop   = 0;
  int   nfe    = 0;
  logic fe_seen, pushed_seen;
  logic force_err;

  always #5 clk = ~clk;

  stack_frame_reverser #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .push_req_n(push_req_n), .pop_req_n(pop_req_n),
    .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
    .stk_empty(stk_empty), .stk_full(stk_full), .stk_error(stk_error),
    .frame_err(frame_err), .stk_fault(stk_fault)
  );

  // Behavioural LIFO: registered pushes/pops, combinational top-of-stack.
  logic [W-1:0] smem [D];
  int           sp;
  logic         serr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp   <= 0;
      serr <= 1'b0;
    end else begin
      if (!push_req_n) begin
        if (sp == D) serr <= 1'b1;
        else begin
          smem[sp] <= stk_data_in;
          sp       <= sp + 1;
        end
      end
      if (!pop_req_n) begin
        if (sp == 0) serr <= 1'b1;
        else sp <= sp - 1;
      end
    end
  end

  assign stk_full     = (sp == D);
  assign stk_empty    = (sp == 0);
  assign stk_data_out = (sp > 0) ? smem[sp-1] : '0;
  assign stk_error    = serr | force_err;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: compares every output handshake against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (!push_req_n) npush++;
      if (!pop_req_n)  npop++;
      if (frame_err)   nfe++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", {24'd0, out_data}, {24'd0, e.d});
          chk("out_last", {31'd0, out_last}, {31'd0, e.l});
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] d, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    fe_seen     = frame_err;
    pushed_seen = !push_req_n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain_remaining", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [W-1:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, f0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1; force_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
    chk("rst_out_valid",  {31'd0, out_valid},  32'd0);
    chk("rst_out_last",   {31'd0, out_last},   32'd0);
    chk("rst_push_req_n", {31'd0, push_req_n}, 32'd1);
    chk("rst_pop_req_n",  {31'd0, pop_req_n},  32'd1);
    chk("rst_frame_err",  {31'd0, frame_err},  32'd0);
    chk("rst_stk_fault",  {31'd0, stk_fault},  32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Three-word frame reversed.
    p0 = npush; q0 = npop; f0 = nfe;
    expect_word(8'h33, 1'b0); expect_word(8'h22, 1'b0); expect_word(8'h11, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    wait_drain();
    chk("f1_pushes", npush - p0, 32'd3);
    chk("f1_pops",   npop - q0,  32'd3);
    chk("f1_no_frame_err", nfe - f0, 32'd0);
    @(negedge clk);
    chk("f1_back_to_fill", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Single-word frame.
    expect_word(8'hA5, 1'b1);
    send_word(8'hA5, 1'b1);
    @(negedge clk);
    chk("sw_out_valid", {31'd0, out_valid}, 32'd1);
    chk("sw_out_data",  {24'd0, out_data},  32'h0000_00A5);
    chk("sw_out_last",  {31'd0, out_last},  32'd1);
    @(negedge clk);
    chk("sw_fill_in_ready",  {31'd0, in_ready},  32'd1);
    chk("sw_fill_out_valid", {31'd0, out_valid}, 32'd0);
    chk("sw_queue_empty", exp_q.size(), 32'd0);
    @(posedge clk); #1;

    // Backpressure: hold for 5 cycles after DRAIN entry.
    out_ready = 1'b0;
    expect_word(8'h33, 1'b0); expect_word(8'h22, 1'b0); expect_word(8'h11, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_data",  {24'd0, out_data},  32'h0000_0033);
      chk("bp_pop_req_n", {31'd0, pop_req_n}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
      chk("bp_out_last",  {31'd0, out_last},  32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain();

    // Overlong frame: words 9 and 10 dropped, frame_err on word 10.
    p0 = npush; f0 = nfe;
    for (int i = 8; i >= 1; i--) expect_word(W'(i), (i == 1));
    for (int i = 1; i <= 10; i++) begin
      send_word(W'(i), (i == 10));
      chk($sformatf("ovf_push_w%0d", i), {31'd0, pushed_seen}, {31'd0, (i <= 8)});
      if (i >= 9) chk($sformatf("ovf_frame_err_w%0d", i), {31'd0, fe_seen}, {31'd0, (i == 10)});
    end
    wait_drain();
    chk("ovf_pushes", npush - p0, 32'd8);
    chk("ovf_frame_err_count", nfe - f0, 32'd1);

    // Reset during DRAIN with two words still stacked.
    expect_word(8'h33, 1'b0);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b1);
    @(posedge clk); #1;
    chk("rd_out_data_before", {24'd0, out_data}, 32'h0000_0022);
    rst = 1'b1;
    #1;
    chk("rd_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rd_pop_req_n",  {31'd0, pop_req_n}, 32'd1);
    chk("rd_in_ready",   {31'd0, in_ready},  32'd1);
    chk("rd_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    expect_word(8'h55, 1'b0); expect_word(8'h44, 1'b1);
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
    wait_drain();

    // Stack error pulse makes stk_fault sticky until reset.
    @(negedge clk);
    chk("se_fault_before", {31'd0, stk_fault}, 32'd0);
    @(posedge clk); #1; force_err = 1'b1;
    @(posedge clk); #1; force_err = 1'b0;
    chk("se_fault_set", {31'd0, stk_fault}, 32'd1);
    expect_word(8'h02, 1'b0); expect_word(8'h01, 1'b1);
    send_word(8'h01, 1'b0);
    send_word(8'h02, 1'b1);
    wait_drain();
    chk("se_fault_held", {31'd0, stk_fault}, 32'd1);
    rst = 1'b1;
    #1;
    chk("se_fault_cleared", {31'd0, stk_fault}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stack_frame_reverser
`default_nettype wire

// File: doc/stack_frame_reverser.md
# stack_frame_reverser

Requester-side controller for a DW_stack instance: accepts a framed word stream on a valid/ready input, pushes each word onto the external stack, and drains the whole frame on a valid/ready output in reverse order. It sits beside a parent-level DW_stack (err_mode 0, rst_mode 0) and owns that stack's push/pop request side. Typical uses are byte/word order reversal and LIFO replay of short command frames.

## Interface
- width, 8, data word width; must equal the stack's width
- depth, 8, stack capacity in words; must equal the stack's depth
- clk  in  1  single clock for the block and the stack
- rst  in  1  asynchronous, active-high reset; the stack's rst_n is driven from the same reset, inverted
- in_valid  in  1  input word present
- in_ready  out  1  block accepts the input word this cycle
- in_data  in  width  input word
- in_last  in  1  marks the last word of the frame
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts the output word
- out_data  out  width  output word, equal to stk_data_out
- out_last  out  1  marks the last output word of the frame
- push_req_n  out  1  stack push request, active low
- pop_req_n  out  1  stack pop request, active low
- stk_data_in  out  width  word to push; equals in_data
- stk_data_out  in  width  top-of-stack word
- stk_empty, stk_full, stk_error  in  1 each  stack status flags
- frame_err  out  1  one-cycle pulse: the frame was truncated
- stk_fault  out  1  sticky; the stack reported an error

## Operation
- Two states: FILL (reset state) and DRAIN. Frame counter cnt has width $clog2(depth+1); it resets to 0.
- FILL:
  - in_ready=1 and out_valid=0.
  - On each accepted beat: if !stk_full, drive push_req_n=0 and increment cnt.
  - If stk_full, drop the word and set the internal trunc flag.
  - An accepted beat with in_last=1 moves the FSM to DRAIN. If trunc is set or that beat was dropped, frame_err pulses in the same cycle. trunc clears.
- DRAIN:
  - in_ready=0, out_valid=1, out_data=stk_data_out, out_last=(cnt==1).
  - Each out_valid&out_ready drives pop_req_n=0 and decrements cnt. The beat with out_last returns the FSM to FILL.
- push_req_n and pop_req_n are never low in the same cycle. Push is only issued in FILL, and pop only in DRAIN.
- stk_error high in any cycle sets stk_fault. Only rst clears it. stk_error does not change FSM operation.
- stk_empty is used only by the checker: in DRAIN, cnt>0 with stk_empty high is a design error (assertion).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0
  - push_req_n=1, pop_req_n=1
  - frame_err=0, stk_fault=0
  - state FILL, cnt=0, trunc=0
- Outputs are combinational from the state and the registers. push_req_n and pop_req_n also depend combinationally on the handshake inputs.
- The first output word is valid in the cycle after in_last is accepted, once the stack has registered the final push.
- Throughput is 1 word/cycle in each phase. An N-word frame (N≤depth) needs N fill cycles plus at least N drain cycles. Fill and drain do not overlap.
- While out_ready is low, out_data, out_last and cnt are held.
- Single-word frame: the next cycle is the DRAIN state with cnt=1 and out_last=1.
- Reset mid-frame returns the block to the reset values immediately. The stack is cleared by the shared reset. There is no partial-frame recovery.

## Structure
- Package stack_frame_reverser_pkg holds the state enum (FILL, DRAIN) and a CNT_W(depth) width function.
- One flat module with no sub-module. The DW_stack is instantiated by the parent, not inside this block.
- Concurrent-assertion checker: no push+pop in the same cycle, no push when stk_full, no pop when cnt==0.

## Test plan
- Reset, then frame 0x11,0x22,0x33 (last on 0x33) -> out 0x33,0x22,0x11, with out_last only on 0x11; exactly 3 pushes and 3 pops.
- Single-word frame 0xA5 -> out_valid next cycle, out_data=0xA5, out_last=1; the following cycle is FILL with in_ready=1.
- Same 3-word frame with out_ready low for 5 cycles after DRAIN entry -> out_data held at 0x33, pop_req_n=1, in_ready=0 throughout.
- depth=8, 10-word frame 1..10 -> no push at words 9 and 10, frame_err pulses on accept of 10, output is 8,7,…,1 with out_last on 1.
- rst asserted during DRAIN with cnt=2 -> same cycle: out_valid=0, pop_req_n=1, in_ready=1. A new frame then reverses correctly.
- stk_error forced high for 1 cycle -> stk_fault=1 and stays high across later frames until rst.
